hilo_muldiv_unit: RTL
=====================

Name: hilo_muldiv_unit

Overview:
- Execute-stage HI/LO responder. It consumes the HI/LO control bundle issued by the pipeline controller: enable, mf-select, signed flag and op.
- Performs MULT/MULTU in 1 cycle and DIV/DIVU with an iterative radix-2 divider over 32 steps. Executes MTHI/MTLO, returns MFHI/MFLO read data, and drives a stall request to the hazard unit while a divide is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- DIV_STEPS, 32, divider iterations; must equal WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hilo_enE  in  1  HI/LO operation valid in E.
- hilo_opE  in  3  000 none, 001 MULT, 010 DIV, 011 MTHI, 100 MTLO; others treated as none.
- hassignE  in  1  1 = signed MULT/DIV, 0 = unsigned.
- hilo_mfE  in  2  00 none, 01 MFHI, 10 MFLO, 11 none.
- srcaE  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- srcbE  in  WIDTH  rt operand (divisor / multiplier).
- flushE  in  1  E-stage flush.
- stall_divE  out  1  stall request to hazard unit.
- hilo_rdataE  out  WIDTH  MFHI/MFLO result, combinational.
- hi_o  out  WIDTH  current HI.
- lo_o  out  WIDTH  current LO.

Behaviour:
- Reset (rst=0, async):
  - HI=0, LO=0, state=IDLE, counter=0, stall_divE=0.
  - Divider datapath registers cleared.
- Requests:
  - req = hilo_enE & ~flushE. No write or start occurs without req.
- MULT (req, op=001, state IDLE):
  - 64-bit product written at the next edge: HI=prod[63:32], LO=prod[31:0].
  - Signed when hassignE=1, otherwise unsigned. No stall.
- MTHI/MTLO (req, IDLE): HI or LO = srcaE at the next edge. No stall.
- MFHI/MFLO:
  - hilo_rdataE = HI or LO from the registers, otherwise 0.
  - A write at edge N is visible to the instruction in E at cycle N+1.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE:
    - On req with op=010: stall_divE=1 combinationally in the same cycle.
    - Latch |srcaE|, |srcbE| (abs only if hassignE), quotient sign = a31^b31, remainder sign = a31. Counter=0, go to BUSY.
  - BUSY:
    - stall_divE=1. One shift-subtract step per cycle, counter+1.
    - After the 32nd step (counter==31), at that edge write HI=remainder and LO=quotient (sign-corrected), then go to DONE.
  - DONE:
    - stall_divE=0, one cycle. The stalled DIV advances.
    - All requests are ignored in this cycle, so the same instruction cannot restart. Go to IDLE.
  - Total stall = 33 cycles (request cycle + 32 BUSY). Result is visible from DONE onward.
- Divide by zero (srcbE=0):
  - Runs the full 33 cycles.
  - Result HI=srcaE (original dividend), LO=all ones, for both signed and unsigned.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- Signed results: quotient truncates toward zero; remainder takes the dividend's sign.
- flushE during BUSY:
  - Abort: go to IDLE at the next edge with HI/LO unchanged.
  - stall_divE is low from the IDLE cycle onward.
- flushE in the IDLE request cycle: no start and stall_divE=0.
- Reset mid-divide: immediate return to IDLE, HI=LO=0.
- Requests while BUSY other than the divide itself: ignored. The hazard unit holds E stable, so only the stalled DIV is present.
- Unused hilo_opE codes and hilo_mfE=11: no state change, rdata 0.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 with random inputs, then release.
  - Required: HI=LO=0, stall_divE=0, hilo_rdataE=0 under MFHI.
- Signed MULT:
  - Stimulus: hassignE=1, srcaE=0xFFFFFFFD (-3), srcbE=5.
  - Required: next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - Repeat with hassignE=0: HI=0x00000004, LO=0xFFFFFFF1.
- DIVU 100/7:
  - Required: stall_divE high for exactly 33 cycles, then HI=2, LO=14 in DONE.
  - An MFLO issued next cycle returns 14.
- Signed DIV -7/2:
  - Required: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Also run 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (srcaE=0x1234):
  - Required: 33-cycle stall, HI=0x1234, LO=0xFFFFFFFF.
  - Also run flushE asserted at BUSY cycle 10: HI/LO keep prior values and stall_divE drops the next cycle.
- MTHI/MTLO:
  - Stimulus: MTHI 0xDEADBEEF, MTLO 0xCAFEF00D, then MFHI and MFLO back-to-back.
  - Required: returns 0xDEADBEEF then 0xCAFEF00D.
  - A request with flushE=1 writes nothing.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// HI/LO execute-stage unit: single-cycle MULT/MULTU, iterative radix-2
// DIV/DIVU (one restoring step per cycle), MTHI/MTLO writes, combinational
// MFHI/MFLO read data and a stall request while a divide is in flight.
module hilo_muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter int DIV_STEPS = 32   // one quotient bit per step, so this must equal WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hilo_enE,
    input  logic [2:0]       hilo_opE,
    input  logic             hassignE,
    input  logic [1:0]       hilo_mfE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    output logic             stall_divE,
    output logic [WIDTH-1:0] hilo_rdataE,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(DIV_STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_MULT = 3'b001,
        OP_DIV  = 3'b010,
        OP_MTHI = 3'b011,
        OP_MTLO = 3'b100
    } hilo_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Divider datapath
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;       // partial remainder
    logic [WIDTH-1:0]   r_quo;       // dividend bits shift out as quotient bits shift in
    logic [WIDTH-1:0]   r_dvsr;      // |divisor|
    logic [WIDTH-1:0]   r_dvnd;      // original dividend, returned in HI on divide by zero
    logic               r_dvsr_zero;
    logic               r_q_neg;
    logic               r_r_neg;

    logic               w_req;
    logic               w_div_start;
    logic               w_div_finish;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_a_sx;
    logic               w_b_sx;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;

    // A flushed instruction is not a request; nothing writes or starts without one.
    assign w_req        = hilo_enE & ~flushE;
    assign w_div_start  = (r_state == S_IDLE) & w_req & (hilo_opE == OP_DIV);
    assign w_div_finish = (r_state == S_BUSY) & ~flushE & (r_cnt == LAST_STEP);

    // Operand magnitudes; -x of the most negative value is itself, which is
    // its correct unsigned magnitude.
    assign w_a_neg = hassignE & srcaE[WIDTH-1];
    assign w_b_neg = hassignE & srcbE[WIDTH-1];
    assign w_a_abs = w_a_neg ? -srcaE : srcaE;
    assign w_b_abs = w_b_neg ? -srcbE : srcbE;

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvsr};
    assign w_fits    = ~w_diff[WIDTH];
    assign w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign w_quo_fix = r_q_neg ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = r_r_neg ? -w_rem_nxt : w_rem_nxt;

    // Extend both operands to the full product width (sign or zero) so one
    // unsigned multiply gives the correct low 2*WIDTH bits in both modes.
    assign w_a_sx  = hassignE & srcaE[WIDTH-1];
    assign w_b_sx  = hassignE & srcbE[WIDTH-1];
    assign w_a_ext = {{WIDTH{w_a_sx}}, srcaE};
    assign w_b_ext = {{WIDTH{w_b_sx}}, srcbE};
    assign w_prod  = w_a_ext * w_b_ext;

    // Divider state register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state and stall request.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        w_state_nxt = r_state;
        stall_divE  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_div_start) begin
                    stall_divE  = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                stall_divE = 1'b1;
                if (flushE)                  w_state_nxt = S_IDLE;
                else if (r_cnt == LAST_STEP) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;  // requests ignored so the DIV cannot restart
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Divider datapath: latch operands on start, one step per BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the datapath is a handful of flops, not a memory, so clearing
        // it on reset is cheap and keeps post-reset state deterministic.
        if (!rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_dvnd      <= '0;
            r_dvsr_zero <= 1'b0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
        end else if (w_div_start) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= w_a_abs;
            r_dvsr      <= w_b_abs;
            r_dvnd      <= srcaE;
            r_dvsr_zero <= (srcbE == '0);
            r_q_neg     <= w_a_neg ^ w_b_neg;
            r_r_neg     <= w_a_neg;
        end else if (r_state == S_BUSY) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // HI/LO registers: divide completion, or a MULT/MTHI/MTLO request in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_div_finish) begin
            if (r_dvsr_zero) begin
                r_hi <= r_dvnd;
                r_lo <= '1;
            end else begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end
        end else if (r_state == S_IDLE && w_req) begin
            case (hilo_opE)
                OP_MULT: begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
                OP_MTHI: r_hi <= srcaE;
                OP_MTLO: r_lo <= srcaE;
                default: ;
            endcase
        end
    end

    // MFHI/MFLO read data straight from the registers.
    always_comb begin
        hilo_rdataE = '0;
        case (hilo_mfE)
            2'b01:   hilo_rdataE = r_hi;
            2'b10:   hilo_rdataE = r_lo;
            default: ;
        endcase
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
